string_packet_sender: RTL
=========================

# string_packet_sender

Transmit-side counterpart of the string detector. Buffers up to DEPTH payload bytes. On a Send pulse, emits a framed packet to the serial transmitter over a valid/ready byte handshake: first a length byte, then the payload bytes in write order. Sits between the host-side byte source and the serial transmitter. It produces exactly the length-prefixed stream that the receive-side detector consumes.

## Interface
- DEPTH, 16: payload buffer capacity in bytes; range 1..255.
- WIDTH, 8: byte width; fixed at 8 (the length byte must fit).
- Clk  input  1  system clock; all logic on its rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Wr_en  input  1  write Wr_data into the buffer this cycle.
- Wr_data  input  8  payload byte.
- Send  input  1  single-cycle request to transmit the buffered packet.
- Tx_ready  input  1  serial transmitter can accept a byte.
- Tx_valid  output  1  Tx_data holds a byte to transfer.
- Tx_data  output  8  byte offered to the transmitter.
- Send_flag  output  1  high from the first offered byte through the last accepted byte.
- Busy  output  1  packet in progress (state is not IDLE).
- Done  output  1  one-cycle pulse after the last byte is accepted.
- Count  output  8  number of payload bytes currently buffered.
- Overflow  output  1  sticky: a write was dropped.

## Operation
- Reset: every output is 0; state is IDLE; buffer pointers are cleared.
- Transfer rule: a byte moves only on a rising edge with Tx_valid=1 and Tx_ready=1.
- While Tx_valid=1 and Tx_ready=0, Tx_data is held stable.
- Tx_valid never drops without a transfer.
- States:
  - IDLE: Wr_en with Count<DEPTH stores the byte and increments Count. Wr_en with Count==DEPTH drops the byte and sets Overflow. Send moves to LEN and latches Len=Count.
  - LEN: Tx_data=Len. On transfer, go to DATA, or to END if Len==0 (CSUM if the checksum is compiled in).
  - DATA: Tx_data=buffer[rd_ptr]. On transfer, increment rd_ptr. After Len bytes, go to END (CSUM if compiled in).
  - CSUM: Tx_data is the XOR of the Len byte and all payload bytes. On transfer, go to END.
  - END: pulse Done, clear Count/rd_ptr/wr_ptr and Overflow, return to IDLE.
- Send with Wr_en in the same IDLE cycle: the write is accepted if there is room, and Len includes it (Len=Count+1).
- Send while Busy: ignored.
- Wr_en while Busy: dropped; sets Overflow.
- Count==0 on Send: a single length byte 0x00 is sent, then Done.
- Rst mid-packet: immediate return to IDLE with buffer contents discarded. A partially sent packet is not resumed.
- The length byte never counts the checksum byte.

## Timing
- Send sampled at edge k: Tx_valid=1 and Send_flag=1 from edge k onward, i.e. LEN is visible in cycle k+1.
- Tx_ready held at 1: one byte per cycle. The packet occupies Len+1 cycles (Len+2 with checksum).
- Done is asserted during the cycle after the final transfer. In that cycle Busy=1, Send_flag=0 and Tx_valid=0.
- Busy falls one cycle after Done; a new Send is accepted from that cycle on.
- Buffer writes have zero-cycle latency: Count updates on the same edge.
- Pointers are log2(DEPTH) bits wide and do not wrap within a packet.

## Configuration
- STRING_SENDER_CHECKSUM_EN defined: the CSUM state exists and one XOR checksum byte is appended after the payload.
- Undefined: no CSUM state and no checksum logic. The packet is exactly the length byte plus the payload.

## Structure
- The shared package holds the state enum (IDLE, LEN, DATA, CSUM, END) and a MAX_LEN=255 constant.
- The package is shared with the receive-side blocks.
- Sub-module: string_sender_buffer, a DEPTH x 8 register array with write pointer, read pointer, Count and full flag.
- The FSM and the handshake stay in the top level.

## Test plan
- Write 0x41,0x42,0x43, Send, Tx_ready=1 -> Tx_data 0x03,0x41,0x42,0x43 on consecutive cycles; Done the next cycle; Count returns to 0.
- Same packet with Tx_ready toggling 1,0,0,1... -> Tx_data stable while stalled; same 4-byte sequence; no duplicates.
- Send with an empty buffer -> single byte 0x00, then Done.
- Write DEPTH+1 bytes -> Count=DEPTH and Overflow=1; the packet carries DEPTH payload bytes; Overflow cleared at END.
- Assert Rst mid-DATA -> all outputs 0 asynchronously; a subsequent Send with no writes sends 0x00.
- With STRING_SENDER_CHECKSUM_EN, send 0x41,0x42 -> bytes 0x02,0x41,0x42,0x01.

Source files
------------

// File: rtl/string_packet_sender_pkg.sv
// string_packet_sender_pkg: sender/detector state encoding and length limit
package string_packet_sender_pkg;
    localparam int MAX_LEN = 255;
    typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, END} state_t;
endpackage

// File: rtl/string_packet_sender_if.sv
// string_packet_sender_if: host write port and transmitter byte handshake
interface string_packet_sender_if;
    logic       Wr_en;
    logic [7:0] Wr_data;
    logic       Send;
    logic       Tx_ready;
    logic       Tx_valid;
    logic [7:0] Tx_data;
    logic       Send_flag;
    logic       Busy;
    logic       Done;
    logic [7:0] Count;
    logic       Overflow;
    modport master(output Wr_en, Wr_data, Send, Tx_ready,
                   input Tx_valid, Tx_data, Send_flag, Busy, Done, Count, Overflow);
    modport slave(input Wr_en, Wr_data, Send, Tx_ready,
                  output Tx_valid, Tx_data, Send_flag, Busy, Done, Count, Overflow);
endinterface

// File: rtl/string_sender_buffer.sv
// string_sender_buffer: DEPTH x WIDTH payload store with write/read pointers and count
module string_sender_buffer #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int PW    = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_inc,
    input  logic             clr,
    output logic [WIDTH-1:0] rd_data,
    output logic [PW-1:0]    rd_ptr,
    output logic [7:0]       count,
    output logic             full
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic             wr_ok;
    assign full    = count == 8'(DEPTH);
    assign wr_ok   = wr_en && !full;
    assign rd_data = mem[rd_ptr];
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= count + 1'b1;
            end
            if (rd_inc) rd_ptr <= rd_ptr + 1'b1;
        end
    always_ff @(posedge Clk)
        if (wr_ok) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/string_packet_sender.sv
// string_packet_sender: buffers payload bytes and sends a length-prefixed packet on Send.
// Define STRING_SENDER_CHECKSUM_EN to append an XOR checksum byte after the payload.
module string_packet_sender
    import string_packet_sender_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input logic                   Clk,
    input logic                   Rst,
    string_packet_sender_if.slave bus
);
    localparam int D  = DEPTH > MAX_LEN ? MAX_LEN : DEPTH;
    localparam int PW = D > 1 ? $clog2(D) : 1;
    state_t           state, nxt;
    logic [7:0]       len, count;
    logic [WIDTH-1:0] rd_data;
    logic [PW-1:0]    rd_ptr;
    logic             full, wr_acc, xfer, last, ovf;
`ifdef STRING_SENDER_CHECKSUM_EN
    localparam state_t TAIL = CSUM;
    logic [7:0] csum;
`else
    localparam state_t TAIL = END;
`endif
    assign wr_acc = bus.Wr_en && state == IDLE;
    assign xfer   = bus.Tx_valid && bus.Tx_ready;
    assign last   = 8'(rd_ptr) + 8'd1 == len;
    string_sender_buffer #(.DEPTH(D), .WIDTH(WIDTH), .PW(PW)) u_buf (
        .Clk(Clk), .Rst(Rst), .wr_en(wr_acc), .wr_data(bus.Wr_data),
        .rd_inc(state == DATA && xfer), .clr(state == END),
        .rd_data(rd_data), .rd_ptr(rd_ptr), .count(count), .full(full)
    );
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) state <= IDLE;
        else state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (bus.Send) nxt = LEN;
            LEN:     if (xfer) nxt = len == 8'd0 ? TAIL : DATA;
            DATA:    if (xfer && last) nxt = TAIL;
            CSUM:    if (xfer) nxt = END;
            default: nxt = IDLE;
        endcase
    end
    // a write coinciding with Send is counted in the length byte
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) begin
            len <= '0;
            ovf <= 1'b0;
        end else begin
            if (state == IDLE && bus.Send) len <= count + 8'(wr_acc && !full);
            ovf <= state == END ? 1'b0 : ovf | (bus.Wr_en && (full || state != IDLE));
        end
`ifdef STRING_SENDER_CHECKSUM_EN
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) csum <= '0;
        else if (state == LEN) csum <= len;
        else if (state == DATA && xfer) csum <= csum ^ 8'(rd_data);
    always_comb bus.Tx_data = state == LEN ? len : state == DATA ? 8'(rd_data) :
                              state == CSUM ? csum : 8'd0;
`else
    always_comb bus.Tx_data = state == LEN ? len : state == DATA ? 8'(rd_data) : 8'd0;
`endif
    assign bus.Tx_valid  = state == LEN || state == DATA || state == CSUM;
    assign bus.Send_flag = bus.Tx_valid;
    assign bus.Busy      = state != IDLE;
    assign bus.Done      = state == END;
    assign bus.Count     = count;
    assign bus.Overflow  = ovf;
endmodule
